// File: rtl/pcs_receive.sv
// pcs_receive: receive-side PCS stage that frames SUDI code groups into GMII RXD/RX_DV/RX_ER.
// Ports:
//   Clk               receive clock, all state changes on its rising edge
//   mr_main_reset     asynchronous active-low reset
//   code_sync_status  1 = upstream synchronizer has acquired sync
//   SUDI[11:0]        [11] unused, [10:1] code group a..j (a = bit 10), [0] rx_even
//   RXD[7:0]          decoded octet HGFEDCBA (registered)
//   RX_DV             receive data valid (registered)
//   RX_ER             receive error (registered)
//   receiving         1 while inside a frame (registered)
module pcs_receive (
    input  logic        Clk,
    input  logic        mr_main_reset,
    input  logic        code_sync_status,
    input  logic [11:0] SUDI,
    output logic [7:0]  RXD,
    output logic        RX_DV,
    output logic        RX_ER,
    output logic        receiving
);
    typedef enum logic [2:0] {
        LINK_FAILED,
        WAIT_FOR_K,
        RX_K,
        IDLE_D,
        RECEIVE,
        TRI,
        TRR
    } state_t;

    // 5b/6b decode: returns {valid, EDCBA}; both disparity columns accepted
    function automatic logic [5:0] dec6(input logic [5:0] s);
        case (s)
            6'b100111, 6'b011000: dec6 = {1'b1, 5'd0};
            6'b011101, 6'b100010: dec6 = {1'b1, 5'd1};
            6'b101101, 6'b010010: dec6 = {1'b1, 5'd2};
            6'b110001:            dec6 = {1'b1, 5'd3};
            6'b110101, 6'b001010: dec6 = {1'b1, 5'd4};
            6'b101001:            dec6 = {1'b1, 5'd5};
            6'b011001:            dec6 = {1'b1, 5'd6};
            6'b111000, 6'b000111: dec6 = {1'b1, 5'd7};
            6'b111001, 6'b000110: dec6 = {1'b1, 5'd8};
            6'b100101:            dec6 = {1'b1, 5'd9};
            6'b010101:            dec6 = {1'b1, 5'd10};
            6'b110100:            dec6 = {1'b1, 5'd11};
            6'b001101:            dec6 = {1'b1, 5'd12};
            6'b101100:            dec6 = {1'b1, 5'd13};
            6'b011100:            dec6 = {1'b1, 5'd14};
            6'b010111, 6'b101000: dec6 = {1'b1, 5'd15};
            6'b011011, 6'b100100: dec6 = {1'b1, 5'd16};
            6'b100011:            dec6 = {1'b1, 5'd17};
            6'b010011:            dec6 = {1'b1, 5'd18};
            6'b110010:            dec6 = {1'b1, 5'd19};
            6'b001011:            dec6 = {1'b1, 5'd20};
            6'b101010:            dec6 = {1'b1, 5'd21};
            6'b011010:            dec6 = {1'b1, 5'd22};
            6'b111010, 6'b000101: dec6 = {1'b1, 5'd23};
            6'b110011, 6'b001100: dec6 = {1'b1, 5'd24};
            6'b100110:            dec6 = {1'b1, 5'd25};
            6'b010110:            dec6 = {1'b1, 5'd26};
            6'b110110, 6'b001001: dec6 = {1'b1, 5'd27};
            6'b001110:            dec6 = {1'b1, 5'd28};
            6'b101110, 6'b010001: dec6 = {1'b1, 5'd29};
            6'b011110, 6'b100001: dec6 = {1'b1, 5'd30};
            6'b101011, 6'b010100: dec6 = {1'b1, 5'd31};
            default:              dec6 = 6'b0;
        endcase
    endfunction

    // 3b/4b decode: returns {valid, HGF}; primary and alternate x.7 forms accepted
    function automatic logic [3:0] dec4(input logic [3:0] s);
        case (s)
            4'b1011, 4'b0100:                   dec4 = {1'b1, 3'd0};
            4'b1001:                            dec4 = {1'b1, 3'd1};
            4'b0101:                            dec4 = {1'b1, 3'd2};
            4'b1100, 4'b0011:                   dec4 = {1'b1, 3'd3};
            4'b1101, 4'b0010:                   dec4 = {1'b1, 3'd4};
            4'b1010:                            dec4 = {1'b1, 3'd5};
            4'b0110:                            dec4 = {1'b1, 3'd6};
            4'b1110, 4'b0001, 4'b0111, 4'b1000: dec4 = {1'b1, 3'd7};
            default:                            dec4 = 4'b0;
        endcase
    endfunction

    state_t     state, state_n;
    logic [7:0] rxd_n;
    logic       dv_n, er_n, rcv_n;
    logic [9:0] cg;
    logic       rx_even;
    logic [5:0] d6;
    logic [3:0] d4;
    logic       data_ok;
    logic [7:0] data;
    logic       is_comma, is_s, is_t, is_r, is_i, comma_even;
    logic       unused_sudi;

    assign unused_sudi = SUDI[11];
    assign cg          = SUDI[10:1];
    assign rx_even     = SUDI[0];
    assign d6          = dec6(cg[9:4]);
    assign d4          = dec4(cg[3:0]);
    assign data_ok     = d6[5] & d4[3];
    assign data        = {d4[2:0], d6[4:0]};

    // /S/, /T/ and /R/ also decode as D27.7, D29.7 and D23.7, so they are
    // matched explicitly and take precedence over the data path
    assign is_comma   = (cg == 10'b0011111010) || (cg == 10'b1100000101);
    assign is_s       = (cg == 10'b1101101000) || (cg == 10'b0010010111);
    assign is_t       = (cg == 10'b1011101000) || (cg == 10'b0100010111);
    assign is_r       = (cg == 10'b1110101000) || (cg == 10'b0001010111);
    assign is_i       = (cg == 10'b1010010110) || (cg == 10'b1001000101) ||
                        (cg == 10'b0110110101);
    assign comma_even = is_comma & rx_even;

    always_ff @(posedge Clk or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            state     <= LINK_FAILED;
            RXD       <= 8'h00;
            RX_DV     <= 1'b0;
            RX_ER     <= 1'b0;
            receiving <= 1'b0;
        end else begin
            state     <= state_n;
            RXD       <= rxd_n;
            RX_DV     <= dv_n;
            RX_ER     <= er_n;
            receiving <= rcv_n;
        end
    end

    always_comb begin
        state_n = state;
        rxd_n   = RXD;
        dv_n    = 1'b0;
        er_n    = 1'b0;
        rcv_n   = receiving;
        // receiving is kept on the forced transition so LINK_FAILED can flag the cut frame
        if (state != LINK_FAILED && !code_sync_status) begin
            state_n = LINK_FAILED;
        end else begin
            case (state)
                LINK_FAILED: begin
                    rcv_n   = 1'b0;
                    er_n    = receiving;
                    state_n = code_sync_status ? WAIT_FOR_K : LINK_FAILED;
                end
                WAIT_FOR_K: state_n = comma_even ? RX_K : WAIT_FOR_K;
                RX_K:       state_n = is_i ? IDLE_D : WAIT_FOR_K;
                IDLE_D: begin
                    if (comma_even) begin
                        state_n = RX_K;
                    end else if (is_s) begin
                        state_n = RECEIVE;
                        dv_n    = 1'b1;
                        rxd_n   = 8'h55;
                        rcv_n   = 1'b1;
                    end else if (!is_comma) begin
                        state_n = WAIT_FOR_K;
                        er_n    = 1'b1;
                    end
                end
                RECEIVE: begin
                    if (is_t) begin
                        state_n = TRI;
                        rcv_n   = 1'b0;
                    end else if (is_comma) begin
                        state_n = RX_K;
                        er_n    = 1'b1;
                        rcv_n   = 1'b0;
                    end else if (is_r) begin
                        state_n = WAIT_FOR_K;
                        er_n    = 1'b1;
                        rcv_n   = 1'b0;
                    end else if (data_ok && !is_s) begin
                        dv_n  = 1'b1;
                        rxd_n = data;
                    end else begin
                        dv_n  = 1'b1;
                        er_n  = 1'b1;
                        rxd_n = 8'h00;
                    end
                end
                TRI: begin
                    state_n = is_r ? TRR : WAIT_FOR_K;
                    er_n    = !is_r;
                end
                TRR:     state_n = is_r ? TRR : (comma_even ? RX_K : WAIT_FOR_K);
                default: state_n = LINK_FAILED;
            endcase
        end
    end
endmodule

// File: tb/tb_pcs_receive.sv
// tb_pcs_receive: self-checking bench for pcs_receive with directed scenarios and random frames.
module tb_pcs_receive;
    logic        Clk = 1'b0;
    logic        mr_main_reset = 1'b0;
    logic        code_sync_status = 1'b0;
    logic [11:0] SUDI = 12'h000;
    logic [7:0]  RXD;
    logic        RX_DV, RX_ER, receiving;
    logic [10:0] obs;
    int          passed = 0;
    int          total = 0;

    localparam logic [9:0] K_N  = 10'b0011111010;
    localparam logic [9:0] S_N  = 10'b1101101000;
    localparam logic [9:0] T_N  = 10'b1011101000;
    localparam logic [9:0] R_N  = 10'b1110101000;
    localparam logic [9:0] I2_N = 10'b1001000101;
    localparam logic [9:0] I2_P = 10'b0110110101;
    localparam logic [9:0] D00  = 10'b1001110100;
    localparam logic [9:0] D215 = 10'b1010101010;
    localparam logic [9:0] D102 = 10'b0101010101;
    localparam logic [9:0] BAD  = 10'b1111111111;

    localparam logic [5:0] C6 [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    localparam logic [3:0] C4 [8] = '{
        4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};

    assign obs = {RXD, RX_DV, RX_ER, receiving};

    pcs_receive dut (
        .Clk(Clk),
        .mr_main_reset(mr_main_reset),
        .code_sync_status(code_sync_status),
        .SUDI(SUDI),
        .RXD(RXD),
        .RX_DV(RX_DV),
        .RX_ER(RX_ER),
        .receiving(receiving)
    );

    always #5 Clk = ~Clk;

    task automatic drive(input logic [9:0] cg, input logic ev);
        SUDI = {1'($urandom), cg, ev};
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [9:0] pick(input logic [9:0] a, input logic [9:0] b);
        return $urandom_range(0, 1) ? a : b;
    endfunction

    // 8b/10b data encoder with random disparity column; x.7 uses the alternate
    // form only where it cannot alias /S/, /T/ or /R/
    function automatic logic [9:0] enc(input logic [7:0] b);
        logic [5:0] s;
        logic [3:0] t;
        s = C6[b[4:0]];
        t = C4[b[7:5]];
        if ($urandom_range(0, 1) && ($countones(s) != 3 || b[4:0] == 5'd7)) s = ~s;
        if (b[7:5] == 3'd7 && !(b[4:0] inside {5'd23, 5'd27, 5'd29}) && $urandom_range(0, 1))
            t = 4'b0111;
        if ($urandom_range(0, 1) && ($countones(t) != 2 || b[7:5] == 3'd3)) t = ~t;
        return {s, t};
    endfunction

    task automatic test_reset();
        repeat (2) @(posedge Clk);
        #1;
        total++;
        if (obs !== 11'h000)
            $display("FAIL reset: got rxd=%h dv/er/rcv=%b want rxd=00 dv/er/rcv=000", obs[10:3], obs[2:0]);
        else passed++;
        #4 mr_main_reset = 1'b1;
        drive(D00, 1'b1);
        total++;
        if (obs !== 11'h000)
            $display("FAIL reset_nosync: got rxd=%h dv/er/rcv=%b want rxd=00 dv/er/rcv=000", obs[10:3], obs[2:0]);
        else passed++;
    endtask

    task automatic test_idle();
        logic [9:0] g [7];
        g = '{K_N, ~K_N, I2_N, K_N, I2_P, ~K_N, I2_N};
        code_sync_status = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(g[i], 1'b1);
            total++;
            if (obs !== 11'h000)
                $display("FAIL idle[%0d]: got rxd=%h dv/er/rcv=%b want rxd=00 dv/er/rcv=000", i, obs[10:3], obs[2:0]);
            else passed++;
        end
    endtask

    task automatic test_frame();
        logic [9:0]  g [8];
        logic [10:0] e [8];
        g = '{S_N, D00, D215, D102, T_N, R_N, K_N, I2_N};
        e = '{{8'h55, 3'b101}, {8'h00, 3'b101}, {8'hB5, 3'b101}, {8'h4A, 3'b101},
              {8'h4A, 3'b000}, {8'h4A, 3'b000}, {8'h4A, 3'b000}, {8'h4A, 3'b000}};
        for (int i = 0; i < 8; i++) begin
            drive(g[i], 1'b1);
            total++;
            if (obs !== e[i])
                $display("FAIL frame[%0d]: got rxd=%h dv/er/rcv=%b want rxd=%h dv/er/rcv=%b", i, obs[10:3], obs[2:0], e[i][10:3], e[i][2:0]);
            else passed++;
        end
    endtask

    task automatic test_invalid();
        logic [9:0]  g [9];
        logic [10:0] e [9];
        g = '{S_N, D215, D102, BAD, D102, T_N, R_N, K_N, I2_N};
        e = '{{8'h55, 3'b101}, {8'hB5, 3'b101}, {8'h4A, 3'b101}, {8'h00, 3'b111}, {8'h4A, 3'b101},
              {8'h4A, 3'b000}, {8'h4A, 3'b000}, {8'h4A, 3'b000}, {8'h4A, 3'b000}};
        for (int i = 0; i < 9; i++) begin
            drive(g[i], 1'b1);
            total++;
            if (obs !== e[i])
                $display("FAIL invalid[%0d]: got rxd=%h dv/er/rcv=%b want rxd=%h dv/er/rcv=%b", i, obs[10:3], obs[2:0], e[i][10:3], e[i][2:0]);
            else passed++;
        end
    endtask

    task automatic test_early_end();
        logic [9:0]  g [9];
        logic [10:0] e [9];
        g = '{S_N, D215, K_N, I2_N, S_N, T_N, R_N, K_N, I2_N};
        e = '{{8'h55, 3'b101}, {8'hB5, 3'b101}, {8'hB5, 3'b010}, {8'hB5, 3'b000}, {8'h55, 3'b101},
              {8'h55, 3'b000}, {8'h55, 3'b000}, {8'h55, 3'b000}, {8'h55, 3'b000}};
        for (int i = 0; i < 9; i++) begin
            drive(g[i], 1'b1);
            total++;
            if (obs !== e[i])
                $display("FAIL early_end[%0d]: got rxd=%h dv/er/rcv=%b want rxd=%h dv/er/rcv=%b", i, obs[10:3], obs[2:0], e[i][10:3], e[i][2:0]);
            else passed++;
        end
    endtask

    task automatic test_sync_loss();
        logic [9:0]  g [17];
        logic        s [17];
        logic [10:0] e [17];
        g = '{S_N, D215, D102, D00, D00, D00, S_N, S_N, D00, I2_N, K_N, I2_N, S_N, T_N, R_N, K_N, I2_N};
        s = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        e = '{{8'h55, 3'b101}, {8'hB5, 3'b101}, {8'h4A, 3'b101}, 11'h000, {8'h4A, 3'b010},
              {8'h4A, 3'b000}, {8'h4A, 3'b000}, {8'h4A, 3'b000}, {8'h4A, 3'b000}, {8'h4A, 3'b000},
              {8'h4A, 3'b000}, {8'h4A, 3'b000}, {8'h55, 3'b101}, {8'h55, 3'b000}, {8'h55, 3'b000},
              {8'h55, 3'b000}, {8'h55, 3'b000}};
        for (int i = 0; i < 17; i++) begin
            code_sync_status = s[i];
            drive(g[i], 1'b1);
            if (i != 3) begin
                total++;
                if (obs !== e[i])
                    $display("FAIL sync_loss[%0d]: got rxd=%h dv/er/rcv=%b want rxd=%h dv/er/rcv=%b", i, obs[10:3], obs[2:0], e[i][10:3], e[i][2:0]);
                else passed++;
            end
        end
    endtask

    task automatic test_async_reset();
        logic [9:0]  g [11];
        logic [10:0] e [11];
        g = '{S_N, D215, S_N, S_N, K_N, I2_N, S_N, T_N, R_N, K_N, I2_N};
        e = '{{8'h55, 3'b101}, {8'hB5, 3'b101}, 11'h000, 11'h000, 11'h000, 11'h000,
              {8'h55, 3'b101}, {8'h55, 3'b000}, {8'h55, 3'b000}, {8'h55, 3'b000}, {8'h55, 3'b000}};
        for (int i = 0; i < 11; i++) begin
            drive(g[i], 1'b1);
            total++;
            if (obs !== e[i])
                $display("FAIL async_reset[%0d]: got rxd=%h dv/er/rcv=%b want rxd=%h dv/er/rcv=%b", i, obs[10:3], obs[2:0], e[i][10:3], e[i][2:0]);
            else passed++;
            if (i == 1) begin
                #2 mr_main_reset = 1'b0;
                #1;
                total++;
                if (obs !== 11'h000)
                    $display("FAIL async_reset_now: got rxd=%h dv/er/rcv=%b want rxd=00 dv/er/rcv=000", obs[10:3], obs[2:0]);
                else passed++;
                #1 mr_main_reset = 1'b1;
            end
        end
    endtask

    // Frames built from idle/frame/termination rules; expected outputs are
    // attached per group as the frame is assembled.
    task automatic test_random_frames();
        logic [10:0] qg [$];
        logic [10:0] qe [$];
        logic [7:0]  l, b;
        int          n, kind;
        for (int f = 0; f < 40; f++) begin
            qg.push_back({pick(S_N, ~S_N), 1'($urandom)});
            qe.push_back({8'h55, 3'b101});
            l = 8'h55;
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    qg.push_back({pick(BAD, 10'b0000000000), 1'($urandom)});
                    qe.push_back({8'h00, 3'b111});
                    l = 8'h00;
                end else begin
                    b = 8'($urandom);
                    qg.push_back({enc(b), 1'($urandom)});
                    qe.push_back({b, 3'b101});
                    l = b;
                end
            end
            kind = $urandom_range(0, 4);
            if (kind == 0 || kind == 4) begin
                qg.push_back({pick(T_N, ~T_N), 1'($urandom)});
                qe.push_back({l, 3'b000});
                for (int i = 0; i <= $urandom_range(0, 3); i++) begin
                    qg.push_back({pick(R_N, ~R_N), 1'($urandom)});
                    qe.push_back({l, 3'b000});
                end
                if (kind == 4) begin
                    qg.push_back({pick(K_N, ~K_N), 1'b1});
                    qe.push_back({l, 3'b000});
                    qg.push_back({pick(I2_N, I2_P), 1'($urandom)});
                    qe.push_back({l, 3'b000});
                    qg.push_back({enc(8'($urandom)), 1'($urandom)});
                    qe.push_back({l, 3'b010});
                end
            end else if (kind == 1) begin
                qg.push_back({pick(K_N, ~K_N), 1'($urandom)});
                qe.push_back({l, 3'b010});
            end else if (kind == 2) begin
                qg.push_back({pick(R_N, ~R_N), 1'($urandom)});
                qe.push_back({l, 3'b010});
            end else begin
                qg.push_back({pick(T_N, ~T_N), 1'($urandom)});
                qe.push_back({l, 3'b000});
                qg.push_back({enc(8'($urandom)), 1'($urandom)});
                qe.push_back({l, 3'b010});
            end
            if (kind != 1) begin
                qg.push_back({pick(K_N, ~K_N), 1'b1});
                qe.push_back({l, 3'b000});
            end
            qg.push_back({pick(I2_N, I2_P), 1'($urandom)});
            qe.push_back({l, 3'b000});
            for (int i = 0; i < $urandom_range(0, 2); i++) begin
                qg.push_back({pick(K_N, ~K_N), 1'b1});
                qe.push_back({l, 3'b000});
                qg.push_back({pick(I2_N, I2_P), 1'($urandom)});
                qe.push_back({l, 3'b000});
            end
        end
        foreach (qg[i]) begin
            drive(qg[i][10:1], qg[i][0]);
            total++;
            if (obs !== qe[i])
                $display("FAIL random[%0d]: got rxd=%h dv/er/rcv=%b want rxd=%h dv/er/rcv=%b", i, obs[10:3], obs[2:0], qe[i][10:3], qe[i][2:0]);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_frame();
        test_invalid();
        test_early_end();
        test_sync_loss();
        test_async_reset();
        test_random_frames();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
